// File: rtl/dot_prod_feeder.sv
// dot_prod_feeder
// Initiator for a dotProd streaming unit. A host fills two DEPTH-entry operand
// buffers, then a start request clears the dotProd accumulator, streams one
// element pair per clock and captures the sum once the unit signals ready.
// A run that never sees dp_ready_i within TIMEOUT wait cycles still completes,
// with err_o set and whatever sum the unit presents at that point.
//
// Optional build macro: DOT_FEED_CHECK_EN
//   Adds a shadow accumulator that sums the streamed products locally and an
//   extra output chk_fail_o that is raised with done_o when the returned sum
//   disagrees with the shadow sum. It is cleared on the next accepted start.
module dot_prod_feeder #(
    parameter int W       = 8,
    parameter int SW      = 16,
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 64,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset_i,
    input  logic          wr_en_i,
    input  logic [AW-1:0] wr_addr_i,
    input  logic [W-1:0]  wr_a_i,
    input  logic [W-1:0]  wr_b_i,
    input  logic          start_i,
    input  logic [AW:0]   len_i,
    output logic          dp_reset_o,
    output logic [W-1:0]  dp_a_o,
    output logic [W-1:0]  dp_b_o,
    input  logic [SW-1:0] dp_s_i,
    input  logic          dp_ready_i,
    output logic          busy_o,
    output logic          done_o,
    output logic [SW-1:0] result_o,
    output logic          err_o
`ifdef DOT_FEED_CHECK_EN
    ,
    output logic          chk_fail_o
`endif
);

    localparam int WCW = $clog2(TIMEOUT + 1);
    localparam logic [AW:0]    DEPTH_V   = (AW + 1)'(DEPTH);
    localparam logic [WCW-1:0] WAIT_LAST = WCW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CLEAR  = 3'd1,
        S_STREAM = 3'd2,
        S_WAIT   = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t         state_q;
    logic [AW:0]    n_q;
    logic [AW:0]    idx_q;
    logic [WCW-1:0] wait_cnt_q;
    logic           dp_reset_q;
    logic [W-1:0]   dp_a_q;
    logic [W-1:0]   dp_b_q;
    logic           busy_q;
    logic           done_q;
    logic [SW-1:0]  result_q;
    logic           err_q;

    logic [W-1:0]   buf_a_q [0:DEPTH-1];
    logic [W-1:0]   buf_b_q [0:DEPTH-1];

    logic [AW:0]    len_clamp_d;
    logic           wr_ok_d;
    logic           wait_exit_d;

    // Decode length clamp, write acceptance and the WAIT exit condition.
    always_comb begin
        len_clamp_d = len_i;
        wr_ok_d     = 1'b0;
        wait_exit_d = 1'b0;
        if (len_i > DEPTH_V) begin
            len_clamp_d = DEPTH_V;
        end else begin
            len_clamp_d = len_i;
        end
        if (wr_en_i && (state_q == S_IDLE) && ({1'b0, wr_addr_i} < DEPTH_V)) begin
            wr_ok_d = 1'b1;
        end else begin
            wr_ok_d = 1'b0;
        end
        if ((state_q == S_WAIT) && (dp_ready_i || (wait_cnt_q == WAIT_LAST))) begin
            wait_exit_d = 1'b1;
        end else begin
            wait_exit_d = 1'b0;
        end
    end

    // Operand buffers: written only while idle; contents are not reset.
    always_ff @(posedge clk) begin
        if (wr_ok_d) begin
            buf_a_q[wr_addr_i] <= wr_a_i;
            buf_b_q[wr_addr_i] <= wr_b_i;
        end
    end

    // Run sequencer; all dotProd-facing and host-facing outputs are registered
    // here so that element k appears on dp_a/dp_b two cycles after start + k.
    always_ff @(posedge clk) begin
        if (reset_i) begin
            state_q    <= S_IDLE;
            n_q        <= '0;
            idx_q      <= '0;
            wait_cnt_q <= '0;
            dp_reset_q <= 1'b1;
            dp_a_q     <= '0;
            dp_b_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            result_q   <= '0;
            err_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    dp_reset_q <= 1'b1;
                    dp_a_q     <= '0;
                    dp_b_q     <= '0;
                    if (start_i) begin
                        n_q    <= len_clamp_d;
                        err_q  <= 1'b0;
                        busy_q <= 1'b1;
                        if (len_clamp_d == '0) begin
                            // Empty run: report zero without releasing dotProd.
                            result_q <= '0;
                            done_q   <= 1'b1;
                            state_q  <= S_DONE;
                        end else begin
                            state_q <= S_CLEAR;
                        end
                    end else begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                S_CLEAR: begin
                    // dp_reset is still high this cycle; release it with element 0.
                    dp_reset_q <= 1'b0;
                    dp_a_q     <= buf_a_q[{AW{1'b0}}];
                    dp_b_q     <= buf_b_q[{AW{1'b0}}];
                    idx_q      <= {{AW{1'b0}}, 1'b1};
                    state_q    <= S_STREAM;
                end
                S_STREAM: begin
                    if (idx_q == n_q) begin
                        // Feed zeros while waiting so the sum is not disturbed.
                        dp_a_q     <= '0;
                        dp_b_q     <= '0;
                        wait_cnt_q <= '0;
                        state_q    <= S_WAIT;
                    end else begin
                        dp_a_q <= buf_a_q[idx_q[AW-1:0]];
                        dp_b_q <= buf_b_q[idx_q[AW-1:0]];
                        idx_q  <= idx_q + {{AW{1'b0}}, 1'b1};
                    end
                end
                S_WAIT: begin
                    if (dp_ready_i) begin
                        result_q <= dp_s_i;
                        done_q   <= 1'b1;
                        state_q  <= S_DONE;
                    end else if (wait_cnt_q == WAIT_LAST) begin
                        result_q <= dp_s_i;
                        err_q    <= 1'b1;
                        done_q   <= 1'b1;
                        state_q  <= S_DONE;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + {{(WCW-1){1'b0}}, 1'b1};
                    end
                end
                S_DONE: begin
                    dp_reset_q <= 1'b1;
                    dp_a_q     <= '0;
                    dp_b_q     <= '0;
                    busy_q     <= 1'b0;
                    state_q    <= S_IDLE;
                end
                default: begin
                    dp_reset_q <= 1'b1;
                    dp_a_q     <= '0;
                    dp_b_q     <= '0;
                    busy_q     <= 1'b0;
                    state_q    <= S_IDLE;
                end
            endcase
        end
    end

    assign dp_reset_o = dp_reset_q;
    assign dp_a_o     = dp_a_q;
    assign dp_b_o     = dp_b_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign result_o   = result_q;
    assign err_o      = err_q;

`ifdef DOT_FEED_CHECK_EN
    logic [2*W-1:0] prod_full_d;
    logic [SW-1:0]  shadow_q;
    logic           chk_fail_q;

    // Product of the pair currently presented to dotProd.
    always_comb begin
        prod_full_d = {{W{1'b0}}, dp_a_q} * {{W{1'b0}}, dp_b_q};
    end

    // Shadow sum of streamed pairs, compared against the captured sum at exit.
    always_ff @(posedge clk) begin
        if (reset_i) begin
            shadow_q   <= '0;
            chk_fail_q <= 1'b0;
        end else if ((state_q == S_IDLE) && start_i) begin
            shadow_q   <= '0;
            chk_fail_q <= 1'b0;
        end else if (state_q == S_STREAM) begin
            shadow_q <= shadow_q + SW'(prod_full_d);
        end else if (wait_exit_d) begin
            chk_fail_q <= (dp_s_i != shadow_q);
        end else begin
            shadow_q   <= shadow_q;
            chk_fail_q <= chk_fail_q;
        end
    end

    assign chk_fail_o = chk_fail_q;
`else
    // Without the check feature the returned sum is trusted as-is.
`endif

endmodule

// File: tb/tb_dot_prod_feeder.sv
// Self-checking bench for dot_prod_feeder. A behavioural dotProd unit (clear on
// dp_reset, otherwise accumulate a*b every clock) answers the feeder; expected
// sums come from the bench's own copy of the operand buffers.
module tb_dot_prod_feeder;
    localparam int W = 8, SW = 16, DEPTH = 8, TIMEOUT = 64, AW = 3;

    logic          clk = 1'b0;
    logic          reset_i = 1'b1;
    logic          wr_en_i = 1'b0;
    logic [AW-1:0] wr_addr_i = '0;
    logic [W-1:0]  wr_a_i = '0;
    logic [W-1:0]  wr_b_i = '0;
    logic          start_i = 1'b0;
    logic [AW:0]   len_i = '0;
    logic          dp_reset_o;
    logic [W-1:0]  dp_a_o;
    logic [W-1:0]  dp_b_o;
    logic [SW-1:0] dp_s_i;
    logic          dp_ready_i = 1'b0;
    logic          busy_o;
    logic          done_o;
    logic [SW-1:0] result_o;
    logic          err_o;
`ifdef DOT_FEED_CHECK_EN
    logic          chk_fail_o;
`endif

    int tests = 0;
    int fails = 0;
    logic [W-1:0]  ref_a [DEPTH];
    logic [W-1:0]  ref_b [DEPTH];
    logic [SW-1:0] acc_q = '0;
    logic [SW-1:0] bias = '0;

    dot_prod_feeder #(.W(W), .SW(SW), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset_i(reset_i), .wr_en_i(wr_en_i), .wr_addr_i(wr_addr_i),
        .wr_a_i(wr_a_i), .wr_b_i(wr_b_i), .start_i(start_i), .len_i(len_i),
        .dp_reset_o(dp_reset_o), .dp_a_o(dp_a_o), .dp_b_o(dp_b_o), .dp_s_i(dp_s_i),
        .dp_ready_i(dp_ready_i), .busy_o(busy_o), .done_o(done_o),
        .result_o(result_o), .err_o(err_o)
`ifdef DOT_FEED_CHECK_EN
        , .chk_fail_o(chk_fail_o)
`endif
    );

    always #5 clk = ~clk;

    // Behavioural dotProd unit; bias lets the bench corrupt the returned sum.
    always @(posedge clk) begin
        if (dp_reset_o) acc_q <= '0;
        else acc_q <= acc_q + 16'(int'(dp_a_o) * int'(dp_b_o));
    end
    assign dp_s_i = acc_q + bias;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic gen_ready(input int mode);
        if (mode == 1) return 1'b1;
        if (mode == 2) return ($urandom_range(0, 3) == 0);
        return 1'b0;
    endfunction

    task automatic write_el(input int addr, input logic [W-1:0] a, input logic [W-1:0] b);
        wr_en_i = 1'b1; wr_addr_i = addr[AW-1:0]; wr_a_i = a; wr_b_i = b;
        tick;
        wr_en_i = 1'b0;
        ref_a[addr] = a; ref_b[addr] = b;
    endtask

    // One complete run: mode 0 never ready, 1 always ready, 2 random ready.
    task automatic run(input int len, input int mode, input bit cowrite, input bit disturb);
        int n, exp_sum, ca;
        logic r;
        logic [W-1:0] na, nb;
        n = (len > DEPTH) ? DEPTH : len;
        start_i = 1'b1;
        len_i = len[AW:0];
        if (cowrite) begin
            ca = $urandom_range(0, DEPTH - 1);
            na = W'($urandom); nb = W'($urandom);
            wr_en_i = 1'b1; wr_addr_i = ca[AW-1:0]; wr_a_i = na; wr_b_i = nb;
            ref_a[ca] = na; ref_b[ca] = nb;
        end
        dp_ready_i = gen_ready(mode);
        tick;
        start_i = 1'b0; wr_en_i = 1'b0;
        exp_sum = 0;
        for (int k = 0; k < n; k++) exp_sum += int'(ref_a[k]) * int'(ref_b[k]);
        exp_sum = exp_sum & 32'h0000FFFF;
        if (n == 0) begin
            chk("empty_done", {31'd0, done_o}, 32'd1);
            chk("empty_result", {16'd0, result_o}, 32'd0);
            chk("empty_dpreset", {31'd0, dp_reset_o}, 32'd1);
            chk("empty_err", {31'd0, err_o}, 32'd0);
            dp_ready_i = 1'b0;
            tick;
            chk("empty_done_low", {31'd0, done_o}, 32'd0);
            chk("empty_idle", {31'd0, busy_o}, 32'd0);
            chk("empty_dpreset2", {31'd0, dp_reset_o}, 32'd1);
            return;
        end
        chk("clear_dpreset", {31'd0, dp_reset_o}, 32'd1);
        chk("clear_busy", {31'd0, busy_o}, 32'd1);
        chk("clear_err", {31'd0, err_o}, 32'd0);
`ifdef DOT_FEED_CHECK_EN
        chk("clear_chkfail", {31'd0, chk_fail_o}, 32'd0);
`endif
        for (int k = 0; k < n; k++) begin
            dp_ready_i = gen_ready(mode);
            if (disturb && k == 0) begin
                start_i = 1'b1; len_i = 4'd1;
                wr_en_i = 1'b1; wr_addr_i = '0; wr_a_i = ~ref_a[0]; wr_b_i = ~ref_b[0];
            end
            tick;
            start_i = 1'b0; wr_en_i = 1'b0;
            chk("stream_dpreset", {31'd0, dp_reset_o}, 32'd0);
            chk("stream_a", {24'd0, dp_a_o}, {24'd0, ref_a[k]});
            chk("stream_b", {24'd0, dp_b_o}, {24'd0, ref_b[k]});
        end
        dp_ready_i = gen_ready(mode);
        tick;
        chk("wait_zero_a", {24'd0, dp_a_o}, 32'd0);
        chk("wait_dpreset", {31'd0, dp_reset_o}, 32'd0);
        r = 1'b0;
        for (int j = 0; j < TIMEOUT; j++) begin
            r = gen_ready(mode);
            dp_ready_i = r;
            tick;
            if (r || j == TIMEOUT - 1) begin
                chk("done_pulse", {31'd0, done_o}, 32'd1);
                break;
            end
            chk("done_early", {31'd0, done_o}, 32'd0);
        end
        dp_ready_i = 1'b0;
        chk("result", {16'd0, result_o}, 32'((exp_sum + int'(bias)) & 32'h0000FFFF));
        chk("err", {31'd0, err_o}, {31'd0, ~r});
`ifdef DOT_FEED_CHECK_EN
        chk("chk_fail", {31'd0, chk_fail_o}, {31'd0, (bias != '0)});
`endif
        tick;
        chk("done_once", {31'd0, done_o}, 32'd0);
        chk("back_idle", {31'd0, busy_o}, 32'd0);
        chk("idle_dpreset", {31'd0, dp_reset_o}, 32'd1);
    endtask

    initial begin
        // Reset held three cycles
        repeat (3) tick;
        chk("rst_dpreset", {31'd0, dp_reset_o}, 32'd1);
        chk("rst_busy", {31'd0, busy_o}, 32'd0);
        chk("rst_done", {31'd0, done_o}, 32'd0);
        chk("rst_result", {16'd0, result_o}, 32'd0);
        chk("rst_err", {31'd0, err_o}, 32'd0);
        reset_i = 1'b0;
        tick;
        for (int i = 0; i < DEPTH; i++) write_el(i, 8'h00, 8'h00);

        // Directed three-element product
        write_el(0, 8'hA3, 8'h24);
        write_el(1, 8'h01, 8'h01);
        write_el(2, 8'h02, 8'h02);
        run(3, 1, 1'b0, 1'b0);
        chk("case2_result", {16'd0, result_o}, 32'h000016F1);

        // Empty run
        run(0, 1, 1'b0, 1'b0);

        // dotProd never answers: timeout path, err held in idle
        run(3, 0, 1'b0, 1'b0);
        tick;
        chk("err_held", {31'd0, err_o}, 32'd1);

        // Start/write while busy are ignored; buffer checked again afterwards
        run(3, 2, 1'b0, 1'b1);
        run(3, 1, 1'b0, 1'b0);
        chk("buf_unchanged", {16'd0, result_o}, 32'h000016F1);

        // Full length with clamp from an oversized len
        for (int i = 0; i < DEPTH; i++) write_el(i, W'($urandom), W'($urandom));
        run(15, 2, 1'b0, 1'b0);
        run(DEPTH, 1, 1'b0, 1'b0);

        // Reset in the middle of streaming aborts without done
        start_i = 1'b1; len_i = 4'd5;
        tick;
        start_i = 1'b0;
        tick; tick;
        chk("abort_streaming", {31'd0, dp_reset_o}, 32'd0);
        reset_i = 1'b1;
        tick;
        reset_i = 1'b0;
        chk("abort_idle", {31'd0, busy_o}, 32'd0);
        chk("abort_dpreset", {31'd0, dp_reset_o}, 32'd1);
        chk("abort_done", {31'd0, done_o}, 32'd0);
        for (int i = 0; i < 8; i++) begin
            tick;
            chk("abort_no_done", {31'd0, done_o}, 32'd0);
        end

        // Randomized runs with optional write alongside start
        for (int it = 0; it < 24; it++) begin
            for (int w = 0; w < 3; w++) write_el($urandom_range(0, DEPTH - 1), W'($urandom), W'($urandom));
            run($urandom_range(0, 15), (it % 8 == 7) ? 0 : $urandom_range(1, 2),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

`ifdef DOT_FEED_CHECK_EN
        // Corrupted sum from dotProd must be flagged
        write_el(0, 8'hA3, 8'h24);
        write_el(1, 8'h01, 8'h01);
        write_el(2, 8'h02, 8'h02);
        bias = 16'hFFFF;
        run(3, 1, 1'b0, 1'b0);
        chk("case6_result", {16'd0, result_o}, 32'h000016F0);
        chk("case6_flag", {31'd0, chk_fail_o}, 32'd1);
        bias = 16'h0000;
        run(3, 1, 1'b0, 1'b0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
